// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and helpers for the SSD command engine.
//   - opcode encodings (read / write; everything else is invalid)
//   - FSM state enum
//   - packed command record carried through the command FIFO
//   - service-latency helper
package ssd_pkg;

    localparam logic [7:0] OP_READ  = 8'd0;
    localparam logic [7:0] OP_WRITE = 8'd1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // 8 + 64 + 32 + 64 = 168 bits.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [63:0] lba;
        logic [31:0] length;
        logic [63:0] data;
    } ssd_cmd_t;

    function automatic logic is_valid_op(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

    // Service latency = base_lat + ceil(length / 2^bpc_log2), saturated to 32 bits.
    // The ceiling is formed as quotient plus "any remainder" so the dividend
    // never needs an extra bit; only the final add can carry into bit 32.
    function automatic logic [31:0] calc_lat(input logic [31:0] length,
                                             input int unsigned base_lat,
                                             input int unsigned bpc_log2);
        logic [31:0] rem_mask;
        logic [32:0] xfer_cycles;
        logic [32:0] total;
        rem_mask    = (32'd1 << bpc_log2) - 32'd1;
        xfer_cycles = {1'b0, length >> bpc_log2}
                    + (((length & rem_mask) != 32'd0) ? 33'd1 : 33'd0);
        total       = xfer_cycles + 33'(base_lat);
        return total[32] ? 32'hFFFF_FFFF : total[31:0];
    endfunction

endpackage

// File: rtl/ssd_cmd_fifo.sv
// ssd_cmd_fifo: synchronous FIFO of ssd_cmd_t commands.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push        write wr_cmd (ignored when full)
//   pop         drop the head entry (ignored when empty)
//   wr_cmd      command to enqueue
//   rd_cmd      current head entry (valid when !empty)
//   full/empty  occupancy flags
//   count       number of stored entries, 0..DEPTH
module ssd_cmd_fifo
    import ssd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  ssd_cmd_t                 wr_cmd,
    output ssd_cmd_t                 rd_cmd,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    ssd_cmd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     cnt_q;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset: an entry is always
    // written before the pointers can expose it, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_cmd;
    end

    assign rd_cmd = mem[rd_ptr];
    assign full   = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign count  = cnt_q;

endmodule

// File: rtl/ssd_cmd_engine.sv
// ssd_cmd_engine: behavioural SSD back end behind the IO chip's SSD interface.
// Commands are accepted on a valid/ready handshake into a small FIFO and
// serviced one at a time with a length-dependent latency (IDLE -> BUSY -> RESP).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; ready is purely FIFO-occupancy based
//   cmd_opcode           0 = read, 1 = write, anything else is invalid
//   cmd_lba              byte address; only the block index bits select a word
//   cmd_length           transfer length in bytes (drives service latency)
//   cmd_data             write payload
//   done                 one-cycle completion pulse
//   rd_data/rd_data_valid read result, qualified together with done
//   resp_err             invalid-opcode completion, qualified with done
//   busy                 engine servicing or commands pending
//   reads_done/writes_done/err_count  wrapping completion counters
module ssd_cmd_engine
    import ssd_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int BASE_LAT   = 2,
    parameter int BPC_LOG2   = 9,
    parameter int BLOCK_LOG2 = 12,
    parameter int MEM_WORDS  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [63:0] cmd_lba,
    input  logic [31:0] cmd_length,
    input  logic [63:0] cmd_data,
    output logic        done,
    output logic [63:0] rd_data,
    output logic        rd_data_valid,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] reads_done,
    output logic [31:0] writes_done,
    output logic [31:0] err_count
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    ssd_cmd_t           in_cmd;
    ssd_cmd_t           head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               push;
    logic               pop;

    state_t             state, state_d;
    logic [31:0]        cnt, cnt_d;

    // Command in service; only the fields needed at RESP are kept.
    logic [7:0]         cur_op;
    logic [IDX_W-1:0]   cur_idx;
    logic [63:0]        cur_data;

    logic [63:0]        store [MEM_WORDS];

    logic               resp_read;
    logic               resp_write;
    logic               unused_head;

    assign in_cmd    = {cmd_opcode, cmd_lba, cmd_length, cmd_data};
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;

    ssd_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wr_cmd (in_cmd),
        .rd_cmd (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // lba bits outside the block index are dropped on purpose (addresses alias).
    assign unused_head = ^head;

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (is_valid_op(head.opcode)) begin
                        cnt_d   = calc_lat(head.length, BASE_LAT, BPC_LOG2);
                        state_d = BUSY;
                    end else begin
                        // Invalid opcodes skip the service delay entirely.
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt - 32'd1;
                // Leaving on cnt == 1 makes BUSY last exactly lat cycles.
                if (cnt == 32'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_op   <= '0;
            cur_idx  <= '0;
            cur_data <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (pop) begin
                cur_op   <= head.opcode;
                cur_idx  <= head.lba[BLOCK_LOG2 +: IDX_W];
                cur_data <= head.data;
            end
        end
    end

    assign resp_read  = (state == RESP) && (cur_op == OP_READ);
    assign resp_write = (state == RESP) && (cur_op == OP_WRITE);

    // The store is cleared on reset so reads of never-written blocks return 0.
    // Writes commit at the end of RESP, ahead of any later command's RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) store[i] <= '0;
        end else if (resp_write) begin
            store[cur_idx] <= cur_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads_done  <= '0;
            writes_done <= '0;
            err_count   <= '0;
        end else if (state == RESP) begin
            if (resp_read)       reads_done  <= reads_done + 32'd1;
            else if (resp_write) writes_done <= writes_done + 32'd1;
            else                 err_count   <= err_count + 32'd1;
        end
    end

    assign done          = (state == RESP);
    assign rd_data_valid = resp_read;
    assign resp_err      = done && !resp_read && !resp_write;
    assign rd_data       = resp_read ? store[cur_idx] : 64'd0;
    assign busy          = (state != IDLE) || (fifo_count != '0);

endmodule
